apb4_master: RTL and testbench

Initiator-side APB4 bridge. It accepts single read or write commands on a valid/ready command port and drives one APB4 transfer per command through the SETUP and ACCESS phases. It returns read data and error status on a valid/ready response port. It sits between an internal requester (test sequencer, DMA-lite, or CPU-side adapter) and the APB4 slaves of the config-register bank, and adds a watchdog so that a slave that never asserts `pready` cannot hang the requester.

---
 rtl/apb4_master.sv | 132 +++++++++++++
 tb/tb_apb4_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_master.sv
// APB4 initiator bridge: one command in, one SETUP/ACCESS transfer out, one response back.
// A watchdog aborts ACCESS after TIMEOUT wait cycles so a stuck completer cannot hang the requester.
module apb4_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    output logic                    psel,
    output logic                    penable,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_cmd_fire;
    logic             w_timeout;

    // Ready is held low during reset so nothing is accepted before the state register settles.
    assign cmd_ready  = (r_state == S_IDLE) && !rst;
    assign w_cmd_fire = cmd_valid && cmd_ready;
    // Fires on the edge that ends the TIMEOUT-th ACCESS cycle with pready still low.
    assign w_timeout  = (TIMEOUT != 0) && !pready
                        && ((32'(r_wait_cnt) + 32'd1) >= TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_cmd_fire) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (pready || w_timeout) w_next = S_RESP;
            S_RESP:   if (rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Saturating wait-state counter, cleared when a new command is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_cmd_fire) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_ACCESS) && !pready && (32'(r_wait_cnt) < TIMEOUT)) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // APB request registers; payload only changes on a command handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            paddr   <= '0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
            pstrb   <= '0;
            pprot   <= '0;
        end else begin
            psel    <= (w_next == S_SETUP) || (w_next == S_ACCESS);
            penable <= (w_next == S_ACCESS);
            if (w_cmd_fire) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
                pstrb  <= cmd_write ? cmd_strb : STRB_W'(0);
                pprot  <= cmd_prot;
            end
        end
    end

    // Response registers; completer data is sampled only when ACCESS meets pready.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= (w_next == S_RESP);
            if (r_state == S_ACCESS) begin
                if (pready) begin
                    rsp_rdata   <= pwrite ? DATA_WIDTH'(0) : prdata;
                    rsp_err     <= pslverr;
                    rsp_timeout <= 1'b0;
                end else if (w_timeout) begin
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb4_master.sv
// Directed and randomized bench for apb4_master acting as the APB completer and the requester.
// Expected responses and phase counts come from a transfer-level model of the bridge behaviour.
module tb_apb4_master;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic          psel;
    logic          penable;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    apb4_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    strb;
        logic [2:0]    prot;
        int            waits;
        logic [DW-1:0] rd;
        logic          se;
    } cmd_t;

    cmd_t cmds [0:31];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_cmd(input cmd_t c);
        cmd_valid = 1'b1;
        cmd_write = c.wr;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        cmd_strb  = c.strb;
        cmd_prot  = c.prot;
    endtask

    // One complete transfer: handshake, APB phases, response with optional backpressure.
    task automatic do_xfer(input int i, input int hold, input bit pend);
        cmd_t        c;
        cmd_t        n;
        bit          is_to;
        int          acc;
        int          exp_acc;
        bit          done;
        logic [31:0] e_rdata;
        logic        e_err;
        logic [3:0]  e_strb;
        c = cmds[i];
        n = cmds[(i + 1) % 32];
        is_to   = (TO != 0) && (c.waits >= int'(TO));
        exp_acc = is_to ? int'(TO) : c.waits + 1;
        e_rdata = (is_to || c.wr) ? 32'h0 : c.rd;
        e_err   = is_to ? 1'b1 : c.se;
        e_strb  = c.wr ? c.strb : 4'h0;

        drive_cmd(c);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        chk("setup_psel", 32'(psel), 32'd1);
        chk("setup_penable", 32'(penable), 32'd0);
        chk("setup_paddr", paddr, c.addr);
        chk("setup_pwrite", 32'(pwrite), 32'(c.wr));
        chk("setup_pwdata", pwdata, c.wdata);
        chk("setup_pstrb", 32'(pstrb), 32'(e_strb));
        chk("setup_pprot", 32'(pprot), 32'(c.prot));
        chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
        step();

        acc  = 0;
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            if (rsp_valid === 1'b1) begin
                done = 1'b1;
            end else begin
                acc++;
                chk("access_psel", 32'(psel), 32'd1);
                chk("access_penable", 32'(penable), 32'd1);
                chk("access_paddr", paddr, c.addr);
                chk("access_pwdata", pwdata, c.wdata);
                chk("access_pstrb", 32'(pstrb), 32'(e_strb));
                pready  = (acc > c.waits);
                prdata  = pready ? c.rd : $urandom;
                pslverr = pready ? c.se : 1'($urandom);
                step();
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = $urandom;
            end
        end
        if (!done) chk("rsp_valid_bound", 32'd0, 32'd1);
        chk("access_cycles", 32'(acc), 32'(exp_acc));

        chk("resp_psel", 32'(psel), 32'd0);
        chk("resp_penable", 32'(penable), 32'd0);
        chk("resp_rdata", rsp_rdata, e_rdata);
        chk("resp_err", 32'(rsp_err), 32'(e_err));
        chk("resp_timeout", 32'(rsp_timeout), 32'(is_to));
        chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);

        if (pend) drive_cmd(n);
        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, e_rdata);
            chk("hold_err", 32'(rsp_err), 32'(e_err));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_psel", 32'(psel), 32'd0);
            chk("hold_paddr", paddr, c.addr);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_psel", 32'(psel), 32'd0);
        chk("idle_paddr_hold", paddr, c.addr);
        chk("idle_ready_after_resp", 32'(cmd_ready), 32'd1);
        if (!pend) cmd_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        cmd_prot  = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        cmds[0] = '{wr:1'b0, addr:32'h4, wdata:32'h0, strb:4'hF, prot:3'd0,
                    waits:0, rd:32'hDEADBEEF, se:1'b0};
        cmds[1] = '{wr:1'b1, addr:32'h8, wdata:32'h12345678, strb:4'h5, prot:3'd2,
                    waits:3, rd:32'hCAFEF00D, se:1'b0};
        cmds[2] = '{wr:1'b0, addr:32'h10, wdata:32'h0, strb:4'h0, prot:3'd1,
                    waits:1, rd:32'hA5A55A5A, se:1'b1};
        cmds[3] = '{wr:1'b0, addr:32'h14, wdata:32'h0, strb:4'h0, prot:3'd0,
                    waits:10, rd:32'h11111111, se:1'b0};
        cmds[4] = '{wr:1'b0, addr:32'h18, wdata:32'h0, strb:4'h0, prot:3'd7,
                    waits:3, rd:32'h0BADF00D, se:1'b0};
        cmds[5] = '{wr:1'b1, addr:32'h1C, wdata:32'h87654321, strb:4'hF, prot:3'd5,
                    waits:0, rd:32'hFFFFFFFF, se:1'b0};
        for (int i = 6; i < 32; i++) begin
            cmds[i].wr    = 1'($urandom);
            cmds[i].addr  = $urandom;
            cmds[i].wdata = $urandom;
            cmds[i].strb  = 4'($urandom);
            cmds[i].prot  = 3'($urandom);
            cmds[i].waits = int'($urandom_range(0, 6));
            cmds[i].rd    = $urandom;
            cmds[i].se    = ($urandom_range(0, 3) == 0);
        end

        step();
        step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_pstrb", 32'(pstrb), 32'd0);
        chk("rst_pprot", 32'(pprot), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        do_xfer(0, 0, 1'b0);
        do_xfer(1, 0, 1'b0);
        do_xfer(2, 1, 1'b0);
        do_xfer(3, 0, 1'b0);
        do_xfer(4, 0, 1'b0);
        do_xfer(5, 5, 1'b1);
        for (int i = 6; i < 29; i++) begin
            do_xfer(i, int'($urandom_range(0, 3)), 1'($urandom));
        end
        do_xfer(29, 2, 1'b0);

        // Reset while the completer is inserting wait states.
        drive_cmd(cmds[3]);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("pre_rst_penable", 32'(penable), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("mid_rst_psel", 32'(psel), 32'd0);
        chk("mid_rst_penable", 32'(penable), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_paddr", paddr, 32'd0);
        chk("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("after_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int k = 0; k < 12; k++) begin
            step();
            chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
            chk("no_psel_after_rst", 32'(psel), 32'd0);
        end
        do_xfer(30, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
